// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the LC-3 MAR/MDR memory access sequencer.
// State encoding and default geometry/timeout values live here so the
// sequencer and its optional timeout counter agree on them.
package mem_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF      = 16;
    localparam int unsigned DATA_W_DEF      = 16;
    localparam int unsigned TIMEOUT_CYC_DEF = 64;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

endpackage

// File: rtl/mem_timeout_ctr.sv
// ACCESS-phase watchdog for mem_access_ctrl. Counts cycles while enabled
// and flags expiry during the TIMEOUT_CYC-th enabled cycle, so the
// sequencer can leave ACCESS on that same edge. Only used when
// MEM_TIMEOUT_EN is defined.
module mem_timeout_ctr
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority, then saturating increment while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (enable_i && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// LC-3 MAR/MDR memory access sequencer (IDLE -> ACCESS -> DONE).
// Drives the external MARMUX select, latches its output into MAR, holds a
// ready handshake with memory and returns load data with a one-cycle ack.
// Optional feature: define MEM_TIMEOUT_EN to abort ACCESS after
// TIMEOUT_CYC cycles without memReady (err pulses with ack).
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              reqWrite,
    input  logic              reqTrap,
    input  logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] marMuxOut,
    output logic              selMAR,
    output logic [ADDR_W-1:0] mar,
    output logic              memEn,
    output logic              memWe,
    output logic [DATA_W-1:0] memWData,
    input  logic [DATA_W-1:0] memRData,
    input  logic              memReady,
    output logic              ack,
    output logic [DATA_W-1:0] rdData,
    output logic              err
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              write_q, write_d;
    logic              trap_q, trap_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              timeout_s;

`ifdef MEM_TIMEOUT_EN
    // Counter is held clear outside ACCESS, so it starts from zero on entry.
    mem_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (state_q != ST_ACCESS),
        .enable_i  (state_q == ST_ACCESS),
        .expired_o (timeout_s)
    );
`else
    // Without the watchdog ACCESS waits forever; the timeout length is moot.
    logic unused_timeout_cfg_s;
    assign unused_timeout_cfg_s = (TIMEOUT_CYC == 0);
    assign timeout_s = 1'b0;
`endif

    // Sequencer next-state and datapath capture; registered outputs are
    // derived from the next state so they line up with the state register.
    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        write_d = write_q;
        trap_d  = trap_q;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_ACCESS;
                    mar_d   = marMuxOut;
                    wdata_d = wrData;
                    write_d = reqWrite;
                    trap_d  = reqTrap;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // Ready beats a coincident timeout.
                if (memReady) begin
                    state_d = ST_DONE;
                    if (!write_q) begin
                        rdata_d = memRData;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (timeout_s) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mem_en_d = (state_d == ST_ACCESS);
        mem_we_d = (state_d == ST_ACCESS) && write_d;
        ack_d    = (state_d == ST_DONE);
    end

    // State, address/data holding registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mar_q    <= {ADDR_W{1'b0}};
            wdata_q  <= {DATA_W{1'b0}};
            rdata_q  <= {DATA_W{1'b0}};
            write_q  <= 1'b0;
            trap_q   <= 1'b0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mar_q    <= mar_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            write_q  <= write_d;
            trap_q   <= trap_d;
            mem_en_q <= mem_en_d;
            mem_we_q <= mem_we_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    // In IDLE the select follows the request directly so marMuxOut settles
    // within the acceptance cycle; afterwards it holds the latched choice.
    assign selMAR   = (state_q == ST_IDLE) ? reqTrap : trap_q;
    assign mar      = mar_q;
    assign memEn    = mem_en_q;
    assign memWe    = mem_we_q;
    assign memWData = wdata_q;
    assign rdData   = rdata_q;
    assign ack      = ack_q;
    assign err      = err_q;

endmodule
